// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID skid buffer: occupancy states and default
// datapath widths.
package ifid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int DEF_PC_W       = 16;
  localparam int DEF_FIELD_W    = 4;
  localparam int DEF_NUM_FIELDS = 4;

endpackage

// File: rtl/if_id_skid_buffer_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_skid_buffer.sv
// Two-entry IF->ID pipeline register with a skid slot, so in_ready depends only
// on occupancy and never combinationally on the ID-side handshake.
module if_id_skid_buffer
  import ifid_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int FIELD_W    = DEF_FIELD_W,
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PC_W-1:0]               in_pc,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_instr,
  input  logic                          hazard,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_W-1:0]               out_pc,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_instr,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int INSTR_W = NUM_FIELDS * FIELD_W;

  buf_state_t         state;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_fire;
  logic               out_fire;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_pc    = main_pc;
  assign out_instr = main_instr;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready & ~hazard;

  // Flush beats everything, including a same-cycle accept, and leaves a NOP on the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state      <= BUSY;
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end else if (in_fire) begin
            state      <= FULL;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state      <= BUSY;
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid & hazard),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed self-checking bench for if_id_skid_buffer: reset, pass-through,
// streaming, hazard fill, flush, asynchronous reset and counter saturation.
module tb_if_id_skid_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        hazard;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [7:0]  stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  if_id_skid_buffer #(
    .PC_W(16), .FIELD_W(4), .NUM_FIELDS(4), .CNT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .hazard   (hazard),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [15:0] pc, input logic [15:0] instr,
                                input logic hz, input logic fl, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    hazard    = hz;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    tick();
    reset = 1'b1;
    #1;
    check_output("post_rst_out_valid", out_valid, 0);
    check_output("post_rst_out_pc", out_pc, 0);
    check_output("post_rst_out_instr", out_instr, 0);
    check_output("post_rst_in_ready", in_ready, 1);
    check_output("post_rst_stall_cnt", stall_cnt, 0);

    // Single pass-through instruction.
    apply_stimulus(1'b1, 16'd15, 16'h2345, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("pass_out_valid", out_valid, 1);
    check_output("pass_out_pc", out_pc, 15);
    check_output("pass_out_instr", out_instr, 16'h2345);
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("pass_drain_valid", out_valid, 0);

    // Back-to-back stream, one per cycle in order.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 16'(40 + i), 16'(16'h4000 + i), 1'b0, 1'b0, 1'b1);
      tick();
      check_output("stream_out_pc", out_pc, 32'(40 + i));
      check_output("stream_in_ready", in_ready, 1);
    end
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("stream_drain_valid", out_valid, 0);

    // Hazard fills both entries, then drains in order.
    apply_stimulus(1'b1, 16'd17, 16'h1111, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("hz_first_pc", out_pc, 17);
    check_output("hz_first_ready", in_ready, 1);
    check_output("hz_first_stall", stall_cnt, 0);
    apply_stimulus(1'b1, 16'd19, 16'h2222, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("hz_full_ready", in_ready, 0);
    check_output("hz_full_pc", out_pc, 17);
    check_output("hz_full_stall", stall_cnt, 1);
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("hz_hold_pc", out_pc, 17);
    check_output("hz_hold_instr", out_instr, 16'h1111);
    check_output("hz_hold_stall", stall_cnt, 2);
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("ordy_low_hold_pc", out_pc, 17);
    check_output("ordy_low_stall", stall_cnt, 2);
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("hz_drain_pc", out_pc, 19);
    check_output("hz_drain_instr", out_instr, 16'h2222);
    check_output("hz_drain_ready", in_ready, 1);
    tick();
    check_output("hz_drain_empty", out_valid, 0);
    check_output("hz_final_stall", stall_cnt, 2);

    // Flush while FULL, with a competing input.
    apply_stimulus(1'b1, 16'd20, 16'h5555, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b1, 16'd22, 16'h6666, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("pre_flush_full", in_ready, 0);
    check_output("pre_flush_stall", stall_cnt, 3);
    apply_stimulus(1'b1, 16'd21, 16'h7777, 1'b1, 1'b1, 1'b1);
    tick();
    check_output("flush_out_valid", out_valid, 0);
    check_output("flush_out_instr", out_instr, 0);
    check_output("flush_out_pc", out_pc, 0);
    check_output("flush_stall_kept", stall_cnt, 4);
    tick();
    check_output("flush_discard_valid", out_valid, 0);
    check_output("flush_discard_pc", out_pc, 0);
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("flush_idle_valid", out_valid, 0);

    // Asynchronous reset while FULL.
    apply_stimulus(1'b1, 16'd24, 16'h8888, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b1, 16'd25, 16'h9999, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 1'b1);
    check_output("arst_pre_full", in_ready, 0);
    check_output("arst_pre_stall", stall_cnt, 5);
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_out_valid", out_valid, 0);
    check_output("arst_in_ready", in_ready, 1);
    check_output("arst_out_pc", out_pc, 0);
    check_output("arst_stall", stall_cnt, 0);
    tick();
    reset = 1'b1;
    apply_stimulus(1'b1, 16'd30, 16'h3333, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("arst_new_pc", out_pc, 30);
    check_output("arst_new_valid", out_valid, 1);

    // Saturation of the stall counter under a long hazard.
    apply_stimulus(1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 1'b1);
    repeat (100) tick();
    check_output("sat_100", stall_cnt, 100);
    repeat (155) tick();
    check_output("sat_255", stall_cnt, 255);
    repeat (45) tick();
    check_output("sat_held", stall_cnt, 255);
    check_output("sat_pc_held", out_pc, 30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
